// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, host-side timeout constants and the
// odd-parity helper used by both the receiver and the command transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StData   = 3'd1,
    StParity = 3'd2,
    StStop   = 3'd3
  } rx_state_e;

  // Timeouts at a 50 MHz system clock
  localparam int unsigned Ps2Cycles2ms  = 100000;
  localparam int unsigned Ps2Bits2ms    = 17;
  localparam int unsigned Ps2Cycles15ms = 750000;
  localparam int unsigned Ps2Bits15ms   = 20;

  // Parity bit value that makes the 9-bit {parity, data} word contain an odd number of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Saturating cycle counter; done is high in the cycle whose clock edge would reach Limit.
module ps2_timeout_counter #(
  parameter int unsigned Width = 17,
  parameter int unsigned Limit = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic done
);

  localparam logic [Width-1:0] LimitVal = Width'(Limit);
  localparam logic [Width-1:0] One      = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LimitVal)) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = run && !clear && (count_q == (LimitVal - One));

endmodule

// File: rtl/ps2_data_in.sv
// Device-to-host PS/2 frame receiver: start, 8 data bits LSB-first, odd parity, stop.
// Bits are sampled on the synchronised PS/2 clock falling-edge strobe only.
module ps2_data_in
  import ps2_pkg::*;
#(
  parameter int unsigned CLOCK_CYCLES_FOR_2MS   = Ps2Cycles2ms,
  parameter int unsigned NUMBER_OF_BITS_FOR_2MS = Ps2Bits2ms
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       receive_enable,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_error,
  output logic       framing_error,
  output logic       timeout_error
);

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       parity_q, parity_d;
  logic [7:0] data_q, data_d;
  logic       data_en_q, data_en_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       timeout_err_q, timeout_err_d;

  logic tmo_clear, tmo_run, tmo_done;

  // Rising-edge strobe is kept only for port compatibility with the transmitter side
  logic unused_posedge;
  assign unused_posedge = ps2_clk_posedge;

  assign tmo_run   = (state_q != StIdle);
  assign tmo_clear = ps2_clk_negedge || !receive_enable || (state_q == StIdle);

  ps2_timeout_counter #(
    .Width(NUMBER_OF_BITS_FOR_2MS),
    .Limit(CLOCK_CYCLES_FOR_2MS)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clear(tmo_clear),
    .run  (tmo_run),
    .done (tmo_done)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    parity_d      = parity_q;
    data_d        = data_q;
    data_en_d     = 1'b0;
    parity_err_d  = 1'b0;
    framing_err_d = 1'b0;
    timeout_err_d = 1'b0;

    if (!receive_enable) begin
      // Disarmed (host transmitting): silently drop any partial frame
      state_d   = StIdle;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ps2_clk_negedge && !ps2_data) begin
            state_d   = StData;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          if (ps2_clk_negedge) begin
            shift_d   = {ps2_data, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StParity;
            end
          end else if (tmo_done) begin
            state_d       = StIdle;
            shift_d       = '0;
            bit_cnt_d     = '0;
            timeout_err_d = 1'b1;
          end
        end
        StParity: begin
          if (ps2_clk_negedge) begin
            parity_d = ps2_data;
            state_d  = StStop;
          end else if (tmo_done) begin
            state_d       = StIdle;
            shift_d       = '0;
            bit_cnt_d     = '0;
            timeout_err_d = 1'b1;
          end
        end
        StStop: begin
          if (ps2_clk_negedge) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            if (!ps2_data) begin
              framing_err_d = 1'b1;
            end else if (parity_q != odd_parity(shift_q)) begin
              parity_err_d = 1'b1;
            end else begin
              data_d    = shift_q;
              data_en_d = 1'b1;
            end
          end else if (tmo_done) begin
            state_d       = StIdle;
            shift_d       = '0;
            bit_cnt_d     = '0;
            timeout_err_d = 1'b1;
          end
        end
        default: begin
          state_d   = StIdle;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      parity_q      <= 1'b0;
      data_q        <= '0;
      data_en_q     <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      parity_q      <= parity_d;
      data_q        <= data_d;
      data_en_q     <= data_en_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign received_data    = data_q;
  assign received_data_en = data_en_q;
  assign parity_error     = parity_err_q;
  assign framing_error    = framing_err_q;
  assign timeout_error    = timeout_err_q;

endmodule
